// File: rtl/led_pattern_sequencer.sv
// LED pattern sequencer: prescaler, step-position register and one-hot decoder
// driving an N_LED bank in rotate-up / rotate-down / bounce / manual modes.
module led_pattern_sequencer #(
  parameter int unsigned N_LED = 8,
  parameter int unsigned DIV   = 25_000_000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [1:0]               mode,
  input  logic                     step_btn,
  output logic [N_LED-1:0]         Led,
  output logic [$clog2(N_LED)-1:0] idx,
  output logic                     tick
);

  localparam int unsigned CW = $clog2(DIV);
  localparam int unsigned IW = $clog2(N_LED);
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(N_LED - 1);
  localparam logic [IW-1:0] IDX_PENU = IW'(N_LED - 2);

  typedef enum logic [1:0] {
    MODE_UP     = 2'b00,
    MODE_DOWN   = 2'b01,
    MODE_BOUNCE = 2'b10,
    MODE_MANUAL = 2'b11
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  mode_e         mode_s;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  dir_e          dir_q, dir_d;
  logic          tick_q, tick_d;
  logic          s1_q, s1_d, s2_q, s2_d, p_q, p_d;
  logic          step_auto, step_man, do_step;

  assign mode_s = mode_e'(mode);

  always_comb begin
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    dir_d     = dir_q;
    step_auto = 1'b0;
    do_step   = 1'b0;
    // Synchronizer and edge flop run regardless of en/mode, so a button
    // already held on entry to manual mode yields no step.
    s1_d      = step_btn;
    s2_d      = s1_q;
    p_d       = s2_q;
    step_man  = s2_q & ~p_q;

    if (en) begin
      if (mode_s == MODE_MANUAL) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end

      step_auto = (mode_s != MODE_MANUAL) && (cnt_q == CNT_LAST);
      do_step   = step_auto || ((mode_s == MODE_MANUAL) && step_man);

      if (mode_s != MODE_BOUNCE) dir_d = DIR_UP;

      if (do_step) begin
        unique case (mode_s)
          MODE_UP, MODE_MANUAL: idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
          MODE_DOWN:            idx_d = (idx_q == '0) ? IDX_LAST : idx_q - IW'(1);
          MODE_BOUNCE: begin
            if (dir_q == DIR_UP) begin
              if (idx_q == IDX_LAST) begin
                idx_d = IDX_PENU;
                dir_d = DIR_DOWN;
              end else begin
                idx_d = idx_q + IW'(1);
              end
            end else begin
              if (idx_q == '0) begin
                idx_d = IW'(1);
                dir_d = DIR_UP;
              end else begin
                idx_d = idx_q - IW'(1);
              end
            end
          end
          default: idx_d = idx_q;
        endcase
      end
    end

    tick_d = step_auto;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      idx_q  <= '0;
      dir_q  <= DIR_UP;
      tick_q <= 1'b0;
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      p_q    <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      dir_q  <= dir_d;
      tick_q <= tick_d;
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      p_q    <= p_d;
    end
  end

  always_comb begin
    Led        = '0;
    Led[idx_q] = 1'b1;
  end

  assign idx  = idx_q;
  assign tick = tick_q;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Directed bench for led_pattern_sequencer with N_LED=8, DIV=4.
module tb_led_pattern_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [1:0] mode;
  logic       step_btn;
  logic [7:0] Led;
  logic [2:0] idx;
  logic       tick;

  int checks = 0;
  int errors = 0;

  led_pattern_sequencer #(.N_LED(8), .DIV(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .mode     (mode),
    .step_btn (step_btn),
    .Led      (Led),
    .idx      (idx),
    .tick     (tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at the falling edge just after a step; waits one full step period.
  task automatic auto_step(input string tag, input logic [2:0] exp_idx);
    repeat (3) @(negedge clk);
    chk({tag, "_tick_lo"}, {31'd0, tick}, 32'd0);
    @(negedge clk);
    chk({tag, "_idx"}, {29'd0, idx}, {29'd0, exp_idx});
    chk({tag, "_led"}, {24'd0, Led}, 32'd1 << exp_idx);
    chk({tag, "_tick_hi"}, {31'd0, tick}, 32'd1);
  endtask

  initial begin
    logic [2:0] bounce_seq [16];
    bounce_seq = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd6,
                   3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd1, 3'd2};

    rst = 1'b0; en = 1'b1; mode = 2'b00; step_btn = 1'b0;
    #12;
    chk("rst_led", {24'd0, Led}, 32'h01);
    chk("rst_idx", {29'd0, idx}, 32'd0);
    chk("rst_tick", {31'd0, tick}, 32'd0);

    // Rotate up: first step lands on the 4th edge after release.
    @(negedge clk); rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("up_pre_led", {24'd0, Led}, 32'h01);
    chk("up_pre_tick", {31'd0, tick}, 32'd0);
    @(negedge clk);
    chk("up1_led", {24'd0, Led}, 32'h02);
    chk("up1_tick", {31'd0, tick}, 32'd1);
    for (int k = 2; k <= 8; k++) auto_step("up", 3'(k % 8));

    // Rotate down from idx 0: wraps to 7 first.
    mode = 2'b01;
    for (int k = 1; k <= 8; k++) auto_step("down", 3'((8 - k) % 8));

    // Bounce from idx 0.
    mode = 2'b10;
    for (int k = 0; k < 16; k++) auto_step("bounce", bounce_seq[k]);

    // Rotate up to 7, then enter bounce at the top endpoint.
    mode = 2'b00;
    for (int k = 3; k <= 7; k++) auto_step("up2", 3'(k));
    mode = 2'b10;
    auto_step("bnc_top", 3'd6);
    auto_step("bnc_top", 3'd5);

    // Freeze with cnt=2.
    repeat (2) @(negedge clk);
    chk("frz_pre_idx", {29'd0, idx}, 32'd5);
    en = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("frz_idx", {29'd0, idx}, 32'd5);
      chk("frz_tick", {31'd0, tick}, 32'd0);
    end
    chk("frz_led", {24'd0, Led}, 32'h20);
    en = 1'b1;
    @(negedge clk);
    chk("resume1_idx", {29'd0, idx}, 32'd5);
    @(negedge clk);
    chk("resume2_idx", {29'd0, idx}, 32'd4);
    chk("resume2_tick", {31'd0, tick}, 32'd1);

    // Async reset between edges at idx 5, while tick is high.
    mode = 2'b00;
    auto_step("pre_rst", 3'd5);
    #2 rst = 1'b0;
    #1;
    chk("arst_led", {24'd0, Led}, 32'h01);
    chk("arst_idx", {29'd0, idx}, 32'd0);
    chk("arst_tick", {31'd0, tick}, 32'd0);
    mode = 2'b11;
    @(negedge clk); rst = 1'b1;

    // Manual: idx changes 2 edges after the first edge sampling the press.
    for (int k = 1; k <= 3; k++) begin
      step_btn = 1'b1;
      @(negedge clk);
      chk("man_e0", {29'd0, idx}, 32'(k - 1));
      @(negedge clk);
      chk("man_e1", {29'd0, idx}, 32'(k - 1));
      @(negedge clk);
      chk("man_e2_idx", {29'd0, idx}, 32'(k));
      chk("man_e2_led", {24'd0, Led}, 32'd1 << k);
      step_btn = 1'b0;
      repeat (5) @(negedge clk);
    end
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      chk("man_hold_idx", {29'd0, idx}, 32'd3);
      chk("man_hold_tick", {31'd0, tick}, 32'd0);
    end

    // Button held while switching into manual: no step until re-pressed.
    mode = 2'b00; step_btn = 1'b1;
    repeat (3) @(negedge clk);
    chk("held_pre_idx", {29'd0, idx}, 32'd3);
    mode = 2'b11;
    repeat (5) @(negedge clk);
    chk("held_idx", {29'd0, idx}, 32'd3);
    step_btn = 1'b0;
    repeat (3) @(negedge clk);
    chk("rel_idx", {29'd0, idx}, 32'd3);
    step_btn = 1'b1;
    repeat (3) @(negedge clk);
    chk("repress_idx", {29'd0, idx}, 32'd4);
    chk("repress_led", {24'd0, Led}, 32'h10);
    step_btn = 1'b0;
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_pattern_sequencer.md
# led_pattern_sequencer

Parametrised LED sequencer: a built-in prescaler, a step-position register, and a one-hot LED decoder in one block. It drives a configurable-width LED bank in four run-time selectable modes: rotate up, rotate down, bounce (ping-pong), and manual single-step from a debounced push-button. It sits directly under the board top level and replaces the fixed 8-LED counter / edge-detect / sequencer / decoder chain.

## Interface
- N_LED, 8, number of LEDs; legal range 2..32
- DIV, 25_000_000, clock cycles per automatic step; legal range ≥ 2
- clk  input  1  system clock; all state changes on its rising edge
- rst  input  1  asynchronous, active-low reset: rst=0 resets immediately, regardless of clk
- en  input  1  1 = run, 0 = freeze prescaler, position and direction (manual steps ignored too)
- mode  input  2  00 rotate-up, 01 rotate-down, 10 bounce, 11 manual
- step_btn  input  1  asynchronous push-button, active-high; used only in mode 11
- Led  output  N_LED  one-hot pattern, bit idx lit
- idx  output  $clog2(N_LED)  current position, registered
- tick  output  1  one-cycle prescaler strobe, registered

## Operation
- Prescaler `cnt` has width $clog2(DIV).
  - While en=1 and mode≠11, it counts 0..DIV-1 and wraps to 0.
  - `step_auto` is high in the cycle where cnt==DIV-1.
  - In mode 11, cnt is held at 0 and step_auto=0.
- tick is step_auto registered, so it is high for exactly one cycle, the cycle after cnt==DIV-1.
- Manual path:
  - Two-flop synchronizer s1→s2 on step_btn, then a previous-value flop p.
  - `step_man` = s2 & ~p. It is used only when mode==11 and en=1.
  - The synchronizer and p run continuously, independent of en and mode. A button already held when entering mode 11 therefore produces no step.
- Position update on a step (step_auto or step_man):
  - Rotate-up: idx = (idx==N_LED-1) ? 0 : idx+1.
  - Rotate-down: idx = (idx==0) ? N_LED-1 : idx-1.
  - Bounce, dir=up: if idx==N_LED-1, then idx=N_LED-2 and dir=down; else idx+1.
  - Bounce, dir=down: if idx==0, then idx=1 and dir=up; else idx-1.
  - Endpoints are never repeated.
  - Manual: same as rotate-up.
- dir register:
  - Used only in bounce mode.
  - Forced to up on any cycle where mode≠10, so every entry into bounce starts upward from the current idx.
  - Exception: if bounce is entered at idx==N_LED-1, the first bounce step goes to N_LED-2 and sets dir=down, per the rule above.
- Led = 1 << idx, decoded combinationally from the idx register.
- Mode change:
  - Takes effect at the next step.
  - Neither cnt nor idx is cleared.
  - Leaving mode 11 restarts cnt from 0.
- en=0 holds cnt, idx, dir and tick=0. On en returning to 1, counting resumes from the held cnt.

## Timing
- Reset values: cnt=0, idx=0, dir=up, s1=s2=p=0, tick=0, Led=1 (bit 0 lit).
- Reset is asynchronous on assertion. On release, the first count occurs on the first rising clk edge with rst=1.
- Automatic step: idx changes on the clk edge that ends the cnt==DIV-1 cycle. tick is high in the cycle after that edge, aligned with the new idx.
- Step period is exactly DIV cycles while en=1.
- Manual latency:
  - step_btn high before edge k sets s1 at k and s2 at k+1.
  - step_man is high in the cycle between edges k+1 and k+2.
  - idx updates at edge k+2.
- Pulses shorter than one clk period may be missed; this is acceptable.
- Reset mid-operation: all state returns to reset values immediately. No partial step is completed.
- Simultaneous mode change and step: the step uses the mode value sampled at that same edge.

## Test plan
- Reset / rotate-up (N_LED=8, DIV=4, mode=00, en=1):
  - Hold rst=0, then release.
  - Required: Led=8'h01, idx=0 during reset.
  - After release, Led becomes 8'h02 after 4 cycles.
  - Sequence 01,02,04,…,80,01 with tick pulses every 4 cycles; wraps 80→01.
- Rotate-down (mode=01) from idx=0:
  - Next step gives Led=8'h80, then 40, 20, …; wraps 01→80.
- Bounce (mode=10) from idx=0, 16 steps:
  - Required idx sequence: 1,2,3,4,5,6,7,6,5,4,3,2,1,0,1,2.
  - Entering bounce at idx=7: first step gives idx=6.
- Enable freeze:
  - Drop en for 10 cycles mid-count (e.g. at cnt=2).
  - Required: idx, Led and cnt unchanged, tick=0.
  - After en=1, the next step occurs 2 cycles later.
- Manual (mode=11):
  - Three step_btn pulses of 3 cycles each, 5 cycles apart.
  - Required: idx advances 0→1→2→3, each change exactly 2 edges after the first edge sampling the press; no automatic steps over 50 cycles.
  - A button held high while switching into mode 11 gives no step until it is released and pressed again.
- Async reset mid-run:
  - Assert rst=0 between clock edges at idx=5.
  - Required: Led=8'h01 and tick=0 immediately, before the next clk edge.
